// File: rtl/sipo_aligner.sv
// ----------------------------------------------------------------------------
// sipo_aligner
//
// Receive end of the 10-bit serial link driven by the piso transmitter.
// Serial bits are shifted into a register. Word boundaries are found by
// detecting the comma pattern or its complement. A three-state lock FSM
// (HUNT / CHECK / LOCKED) qualifies the alignment before any word is passed
// on to the 10b word consumer (decoder / elastic buffer).
//
// Bit [0] of every word is the first bit seen on the line. New bits enter at
// the MSB and the register shifts towards bit [0]. When a word is complete,
// its first bit therefore sits in bit [0].
//
// Parameters
//   WIDTH         word width in bits
//   COMMA         alignment pattern; its bitwise complement also matches
//   LOCK_COMMAS   consecutive aligned commas needed to reach LOCKED (>= 2)
//   MISALIGN_MAX  misaligned commas tolerated in LOCKED before re-hunting (>= 1)
//
// Ports
//   clk           in   1      single clock, rising edge
//   reset         in   1      synchronous, active-high reset
//   serial_in     in   1      serial data, one bit per clk while enable=1
//   enable        in   1      bit strobe; 0 freezes shifter, FSM and counters
//   int_re        out  WIDTH  raw shift register (debug view)
//   parallel_out  out  WIDTH  last aligned word, held between data_valid pulses
//   data_valid    out  1      one-cycle pulse: parallel_out updated this cycle
//   is_comma      out  1      parallel_out is COMMA or ~COMMA (with data_valid)
//   locked        out  1      high while the FSM is in LOCKED
// ----------------------------------------------------------------------------
module sipo_aligner #(
    parameter int                WIDTH        = 10,
    parameter logic [WIDTH-1:0]  COMMA        = 10'b0011111010,
    parameter int                LOCK_COMMAS  = 3,
    parameter int                MISALIGN_MAX = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             serial_in,
    input  logic             enable,
    output logic [WIDTH-1:0] int_re,
    output logic [WIDTH-1:0] parallel_out,
    output logic             data_valid,
    output logic             is_comma,
    output logic             locked
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CW = $clog2(LOCK_COMMAS + 1);
    localparam int EW = (MISALIGN_MAX > 0) ? $clog2(MISALIGN_MAX + 1) : 1;

    localparam logic [BW-1:0] LAST_BIT   = BW'(WIDTH - 1);
    localparam logic [CW-1:0] LOCK_COUNT = CW'(LOCK_COMMAS);
    localparam logic [EW-1:0] ERR_LIMIT  = EW'(MISALIGN_MAX);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [BW-1:0]     bit_cnt;
    logic [BW-1:0]     bit_cnt_next;
    logic [CW-1:0]     comma_cnt;
    logic [CW-1:0]     comma_cnt_next;
    logic [CW-1:0]     comma_cnt_inc;
    logic [EW-1:0]     err_cnt;
    logic [EW-1:0]     err_cnt_next;
    logic [EW-1:0]     err_cnt_inc;
    logic [WIDTH-1:0]  int_re_next;
    logic [WIDTH-1:0]  parallel_next;
    logic              data_valid_next;
    logic              is_comma_next;
    logic              locked_next;

    logic [WIDTH-1:0]  nxt;
    logic              comma_hit;
    logic              at_boundary;

    // All comparisons look at the register value the current bit is about to
    // produce, so that a comma is recognised on the same edge its last bit
    // arrives.
    assign nxt           = {serial_in, int_re[WIDTH-1:1]};
    assign comma_hit     = (nxt == COMMA) || (nxt == ~COMMA);
    assign at_boundary   = enable && (bit_cnt == LAST_BIT);
    assign comma_cnt_inc = comma_cnt + CW'(1);
    assign err_cnt_inc   = err_cnt + EW'(1);

    // State register and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= HUNT;
            bit_cnt      <= '0;
            comma_cnt    <= '0;
            err_cnt      <= '0;
            int_re       <= '0;
            parallel_out <= '0;
            data_valid   <= 1'b0;
            is_comma     <= 1'b0;
            locked       <= 1'b0;
        end else begin
            state        <= state_next;
            bit_cnt      <= bit_cnt_next;
            comma_cnt    <= comma_cnt_next;
            err_cnt      <= err_cnt_next;
            int_re       <= int_re_next;
            parallel_out <= parallel_next;
            data_valid   <= data_valid_next;
            is_comma     <= is_comma_next;
            locked       <= locked_next;
        end
    end

    // Next-state and next-output logic. With enable low, everything holds
    // and only data_valid drops.
    always_comb begin
        state_next      = state;
        bit_cnt_next    = bit_cnt;
        comma_cnt_next  = comma_cnt;
        err_cnt_next    = err_cnt;
        int_re_next     = int_re;
        parallel_next   = parallel_out;
        data_valid_next = 1'b0;
        is_comma_next   = is_comma;
        locked_next     = locked;

        if (enable) begin
            int_re_next  = nxt;
            bit_cnt_next = (bit_cnt == LAST_BIT) ? '0 : bit_cnt + BW'(1);

            unique case (state)
                HUNT: begin
                    // The bit counter runs freely here. A comma re-phases it
                    // so that the next boundary lands one word later.
                    if (comma_hit) begin
                        bit_cnt_next   = '0;
                        comma_cnt_next = CW'(1);
                        state_next     = CHECK;
                    end
                end

                CHECK: begin
                    if (at_boundary) begin
                        if (comma_hit) begin
                            if (comma_cnt_inc == LOCK_COUNT) begin
                                state_next      = LOCKED;
                                locked_next     = 1'b1;
                                comma_cnt_next  = '0;
                                err_cnt_next    = '0;
                                parallel_next   = nxt;
                                data_valid_next = 1'b1;
                                is_comma_next   = 1'b1;
                            end else begin
                                comma_cnt_next = comma_cnt_inc;
                            end
                        end else begin
                            state_next     = HUNT;
                            comma_cnt_next = '0;
                        end
                    end
                end

                LOCKED: begin
                    if (at_boundary) begin
                        parallel_next   = nxt;
                        data_valid_next = 1'b1;
                        is_comma_next   = comma_hit;
                        if (comma_hit) begin
                            err_cnt_next = '0;
                        end
                    end else if (comma_hit) begin
                        // A comma off the word grid means the link slipped.
                        // It is never forwarded. Only repeated slips drop
                        // the lock, so that a single corrupted bit pattern
                        // does not cause a realignment.
                        if (err_cnt_inc == ERR_LIMIT) begin
                            state_next     = HUNT;
                            locked_next    = 1'b0;
                            err_cnt_next   = '0;
                            comma_cnt_next = '0;
                        end else begin
                            err_cnt_next = err_cnt_inc;
                        end
                    end
                end

                default: begin
                    state_next     = HUNT;
                    locked_next    = 1'b0;
                    comma_cnt_next = '0;
                    err_cnt_next   = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sipo_aligner.sv
// ----------------------------------------------------------------------------
// tb_sipo_aligner
//
// Directed testbench for sipo_aligner. Every word the aligner should emit is
// pushed onto a scoreboard queue before its bits are driven. A monitor on the
// falling edge pops one entry per data_valid pulse. Between pulses it checks
// that parallel_out holds the last emitted word.
// ----------------------------------------------------------------------------
module tb_sipo_aligner;

    localparam int         WIDTH = 10;
    localparam logic [9:0] COMMA = 10'b0011111010;

    logic             clk       = 1'b0;
    logic             reset     = 1'b1;
    logic             serial_in = 1'b0;
    logic             enable    = 1'b0;
    logic [WIDTH-1:0] int_re;
    logic [WIDTH-1:0] parallel_out;
    logic             data_valid;
    logic             is_comma;
    logic             locked;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [9:0] word;
        logic       comma;
    } exp_t;

    exp_t       exp_q[$];
    logic [9:0] held_word = '0;

    sipo_aligner #(
        .WIDTH        (WIDTH),
        .COMMA        (COMMA),
        .LOCK_COMMAS  (3),
        .MISALIGN_MAX (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .serial_in    (serial_in),
        .enable       (enable),
        .int_re       (int_re),
        .parallel_out (parallel_out),
        .data_valid   (data_valid),
        .is_comma     (is_comma),
        .locked       (locked)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [15:0] observed,
                                input logic [15:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drives one clock of inputs. Returns just after the rising edge, so
    // registered outputs of that edge can be checked right away.
    task automatic apply_stimulus(input logic b, input logic en);
        @(negedge clk);
        serial_in = b;
        enable    = en;
        @(posedge clk);
        #1;
    endtask

    // Sends a word, bit [0] first. Optionally inserts random idle gaps with
    // enable low and garbage on the line.
    task automatic send_word(input logic [9:0] w, input int max_gap);
        for (int i = 0; i < 10; i++) begin
            if (max_gap > 0) begin
                int g;
                g = int'($urandom_range(max_gap, 0));
                repeat (g) apply_stimulus(1'($urandom_range(1, 0)), 1'b0);
            end
            apply_stimulus(w[i], 1'b1);
        end
    endtask

    task automatic expect_word(input logic [9:0] w, input logic c);
        exp_t e;
        e.word  = w;
        e.comma = c;
        exp_q.push_back(e);
    endtask

    // Holds reset for n rising edges while the line toggles with enable high.
    task automatic do_reset(input int n);
        repeat (n) begin
            @(negedge clk);
            reset     = 1'b1;
            enable    = 1'b1;
            serial_in = ~serial_in;
        end
        @(negedge clk);
        reset     = 1'b0;
        enable    = 1'b0;
        held_word = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_int_re"},       16'(int_re),       16'd0);
        check_output({tag, "_parallel_out"}, 16'(parallel_out), 16'd0);
        check_output({tag, "_data_valid"},   16'(data_valid),   16'd0);
        check_output({tag, "_is_comma"},     16'(is_comma),     16'd0);
        check_output({tag, "_locked"},       16'(locked),       16'd0);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (data_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check_output("unexpected_data_valid", 16'(data_valid), 16'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check_output("word",         16'(parallel_out), 16'(e.word));
                    check_output("is_comma",     16'(is_comma),     16'(e.comma));
                    check_output("locked_on_dv", 16'(locked),       16'd1);
                    held_word = e.word;
                end
            end else begin
                check_output("hold_parallel_out", 16'(parallel_out), 16'(held_word));
            end
        end
    end

    initial begin
        logic [9:0] c;
        logic [9:0] w1;
        logic [9:0] w2;
        logic [9:0] slip_a;
        logic [9:0] slip_b;

        c  = COMMA;
        w1 = 10'b0101010101;
        w2 = 10'b1100110011;
        // Words seen on the old grid after a 3-bit slip of 000 ahead of commas
        slip_a = {c[6:0], 3'b000};
        slip_b = {c[6:0], c[9:7]};

        // Reset with activity on the line
        do_reset(3);
        check_reset_outputs("reset");

        // Junk, then three aligned commas to lock
        apply_stimulus(1'b1, 1'b1);
        apply_stimulus(1'b0, 1'b1);
        apply_stimulus(1'b1, 1'b1);
        apply_stimulus(1'b1, 1'b1);
        send_word(COMMA, 0);
        check_output("locked_after_comma1", 16'(locked), 16'd0);
        send_word(COMMA, 0);
        check_output("locked_after_comma2", 16'(locked), 16'd0);
        expect_word(COMMA, 1'b1);
        send_word(COMMA, 0);
        check_output("locked_after_comma3", 16'(locked), 16'd1);
        check_output("lock_dv_latency",     16'(data_valid), 16'd1);
        check_output("int_re_comma",        16'(int_re), 16'(COMMA));

        // Data words while locked
        expect_word(w1, 1'b0);
        send_word(w1, 0);
        check_output("data1_dv_latency", 16'(data_valid), 16'd1);
        expect_word(w2, 1'b0);
        send_word(w2, 0);
        check_output("data2_dv_latency", 16'(data_valid), 16'd1);
        repeat (5) apply_stimulus(1'b0, 1'b0);
        check_output("hold_after_idle", 16'(parallel_out), 16'(w2));
        check_output("dv_low_idle",     16'(data_valid),   16'd0);

        // Same words with enable gaps inside them
        expect_word(w1, 1'b0);
        send_word(w1, 3);
        expect_word(w2, 1'b0);
        send_word(w2, 3);
        repeat (3) apply_stimulus(1'b1, 1'b0);
        check_output("locked_after_gaps", 16'(locked), 16'd1);

        // Slip by three bits: two misaligned commas drop lock, three relock
        apply_stimulus(1'b0, 1'b1);
        apply_stimulus(1'b0, 1'b1);
        apply_stimulus(1'b0, 1'b1);
        expect_word(slip_a, 1'b0);
        send_word(COMMA, 0);
        check_output("locked_after_misalign1", 16'(locked), 16'd1);
        expect_word(slip_b, 1'b0);
        send_word(COMMA, 0);
        check_output("locked_after_misalign2", 16'(locked), 16'd0);
        send_word(COMMA, 0);
        send_word(COMMA, 0);
        check_output("locked_new_offset_2", 16'(locked), 16'd0);
        expect_word(COMMA, 1'b1);
        send_word(COMMA, 0);
        check_output("relocked_new_offset", 16'(locked), 16'd1);

        // Reset in the middle of a word
        for (int i = 0; i < 5; i++) apply_stimulus(w1[i], 1'b1);
        do_reset(2);
        check_reset_outputs("midword_reset");

        // From HUNT: two commas then a non-comma word fall back to HUNT
        send_word(COMMA, 0);
        send_word(COMMA, 0);
        send_word(10'h3FF, 0);
        check_output("locked_after_bad_word", 16'(locked), 16'd0);
        send_word(COMMA, 0);
        send_word(COMMA, 0);
        check_output("locked_fresh_comma2", 16'(locked), 16'd0);
        expect_word(COMMA, 1'b1);
        send_word(COMMA, 0);
        check_output("locked_fresh_comma3", 16'(locked), 16'd1);

        repeat (4) apply_stimulus(1'b0, 1'b0);
        check_output("scoreboard_empty", 16'(exp_q.size()), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
